// File: rtl/mem_program_seq.sv
// Program memory loader/sequencer: a session writes words from PC_INITIAL upward,
// load_done locks the array, and only the loaded range may then be fetched.
module mem_program_seq #(
  parameter int INSTR_WIDTH = 32,
  parameter int MEM_WIDTH   = 8,
  parameter int PC_INITIAL  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_done,
  output logic                   load_ready,
  output logic                   lock,
  output logic [MEM_WIDTH:0]     word_count,
  input  logic                   fetch_req,
  input  logic [MEM_WIDTH-1:0]   fetch_addr,
  output logic [INSTR_WIDTH-1:0] fetch_data,
  output logic                   fetch_valid,
  output logic                   err
);

  localparam int DEPTH = 2 ** MEM_WIDTH;
  localparam int CAP   = DEPTH - PC_INITIAL;
  localparam int CW    = MEM_WIDTH + 1;
  localparam int RW    = MEM_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, LOAD, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          word_count_q, word_count_d;
  logic                   err_q, err_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic [INSTR_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic                   wr_en;
  logic [MEM_WIDTH-1:0]   wr_addr;
  logic [RW-1:0]          fetch_off;
  logic                   hit;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d       = state_q;
    word_count_d  = word_count_q;
    err_d         = err_q;
    wr_en         = 1'b0;
    fetch_valid_d = fetch_req;
    fetch_data_d  = fetch_data_q;
    load_ready    = (state_q == LOAD) && (word_count_q < CW'(CAP));
    // Write pointer is derived from the count, so it can never pass DEPTH-1.
    wr_addr       = MEM_WIDTH'(PC_INITIAL) + word_count_q[MEM_WIDTH-1:0];
    // Addresses below PC_INITIAL wrap to a large offset and fail the compare.
    fetch_off     = RW'(fetch_addr) - RW'(PC_INITIAL);
    hit           = fetch_off < RW'(word_count_q);

    if (load_start) begin
      state_d      = LOAD;
      word_count_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_valid) begin
            if (load_ready) begin
              wr_en        = 1'b1;
              word_count_d = word_count_q + CW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
          if (load_done) state_d = LOCKED;
        end
        default: begin
          if (load_valid) err_d = 1'b1;
        end
      endcase
    end

    if (fetch_req) begin
      if (state_q == LOCKED && hit) begin
        fetch_data_d = mem[fetch_addr];
      end else begin
        fetch_data_d = '0;
        err_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      word_count_q  <= '0;
      err_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      word_count_q  <= word_count_d;
      err_q         <= err_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  // Array is never reset; stale words stay unreachable via the range check.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= load_data;
  end

  assign lock        = (state_q == LOCKED);
  assign word_count  = word_count_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_program_seq.sv
// Scoreboard bench for mem_program_seq (INSTR_WIDTH=32, MEM_WIDTH=2, PC_INITIAL=0).
module tb_mem_program_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_valid, load_done;
  logic [31:0] load_data;
  logic        load_ready, lock;
  logic [2:0]  word_count;
  logic        fetch_req;
  logic [1:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid, err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mem_program_seq #(
    .INSTR_WIDTH(32),
    .MEM_WIDTH  (2),
    .PC_INITIAL (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_done  (load_done),
    .load_ready (load_ready),
    .lock       (lock),
    .word_count (word_count),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every fetch_valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL fetch_unexpected: fetch_valid with no request pending, data=%h", fetch_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (fetch_data !== e) begin
          failures++;
          $display("FAIL fetch_data: got %h expected %h", fetch_data, e);
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic start_session;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w, input logic done);
    load_valid = 1'b1;
    load_data  = w;
    load_done  = done;
    cyc();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic close_session;
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;
  endtask

  task automatic fetch_one(input logic [1:0] a, input logic [31:0] e);
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_q.push_back(e);
    cyc();
    fetch_req  = 1'b0;
    cyc();
  endtask

  task automatic load_three;
    do_reset();
    start_session();
    put_word(32'h0050, 1'b0);
    put_word(32'h0850, 1'b0);
    put_word(32'h8152, 1'b0);
    close_session();
  endtask

  task automatic test_reset;
    load_start = 0; load_valid = 0; load_done = 0; load_data = '0;
    fetch_req = 0; fetch_addr = '0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    checks++;
    if ({lock, word_count, fetch_valid, fetch_data, err, load_ready} !== {1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got lock=%b wc=%0d fv=%b fd=%h err=%b rdy=%b expected all zero",
               lock, word_count, fetch_valid, fetch_data, err, load_ready);
    end
  endtask

  task automatic test_idle_inputs;
    do_reset();
    close_session();
    checks++;
    if (lock !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL idle_load_done: got lock=%b err=%b expected lock=0 err=0", lock, err);
    end
    put_word(32'hDEAD, 1'b0);
    checks++;
    if (err !== 1'b1 || word_count !== 3'd0) begin
      failures++;
      $display("FAIL idle_load_valid: got err=%b wc=%0d expected err=1 wc=0", err, word_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_words [3];
    exp_words[0] = 32'h0050; exp_words[1] = 32'h0850; exp_words[2] = 32'h8152;
    load_three();
    checks++;
    if (lock !== 1'b1 || word_count !== 3'd3 || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_lock: got lock=%b wc=%0d err=%b expected 1 3 0", lock, word_count, err);
    end
    for (int i = 0; i < 3; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 2'(i);
      exp_q.push_back(exp_words[i]);
      cyc();
      checks++;
      if (fetch_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_valid: cycle %0d got fetch_valid=%b expected 1", i, fetch_valid);
      end
    end
    fetch_req = 1'b0;
    cyc();
    checks++;
    if (fetch_valid !== 1'b0 || fetch_data !== 32'h8152) begin
      failures++;
      $display("FAIL b2b_hold: got fv=%b fd=%h expected fv=0 fd=00008152", fetch_valid, fetch_data);
    end
    checks++;
    if (exp_q.size() != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got pending=%0d err=%b expected 0 0", exp_q.size(), err);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    start_session();
    load_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (load_ready !== (j < 4)) begin
        failures++;
        $display("FAIL overflow_ready: word %0d got load_ready=%b expected %b", j, load_ready, j < 4);
      end
      load_data = 32'hA000 + 32'(j);
      cyc();
    end
    load_valid = 1'b0;
    checks++;
    if (word_count !== 3'd4 || err !== 1'b1 || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL overflow_state: got wc=%0d err=%b rdy=%b expected 4 1 0", word_count, err, load_ready);
    end
    close_session();
    for (int j = 0; j < 4; j++) fetch_one(2'(j), 32'hA000 + 32'(j));
  endtask

  task automatic test_out_of_range;
    load_three();
    fetch_one(2'd3, 32'd0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL range_err: got err=%b expected 1", err);
    end
  endtask

  task automatic test_done_with_word;
    do_reset();
    start_session();
    put_word(32'h1450, 1'b0);
    put_word(32'h1550, 1'b1);
    checks++;
    if (word_count !== 3'd2 || lock !== 1'b1) begin
      failures++;
      $display("FAIL done_same_cycle: got wc=%0d lock=%b expected 2 1", word_count, lock);
    end
    fetch_one(2'd1, 32'h1550);
    fetch_one(2'd0, 32'h1450);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL done_same_err: got err=%b expected 0", err);
    end
  endtask

  task automatic test_rst_midload;
    do_reset();
    start_session();
    put_word(32'h3001, 1'b0);
    put_word(32'h3002, 1'b0);
    load_valid = 1'b1;
    load_data  = 32'h3003;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (lock !== 1'b0 || word_count !== 3'd0 || load_ready !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_midload: got lock=%b wc=%0d rdy=%b err=%b expected 0 0 0 0",
               lock, word_count, load_ready, err);
    end
    fetch_one(2'd0, 32'd0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL rst_fetch_err: got err=%b expected 1", err);
    end
  endtask

  task automatic test_reload;
    load_three();
    start_session();
    checks++;
    if (lock !== 1'b0 || load_ready !== 1'b1 || word_count !== 3'd0) begin
      failures++;
      $display("FAIL reload_open: got lock=%b rdy=%b wc=%0d expected 0 1 0", lock, load_ready, word_count);
    end
    put_word(32'h2875, 1'b1);
    checks++;
    if (word_count !== 3'd1 || lock !== 1'b1) begin
      failures++;
      $display("FAIL reload_lock: got wc=%0d lock=%b expected 1 1", word_count, lock);
    end
    fetch_one(2'd0, 32'h2875);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reload_err: got err=%b expected 0", err);
    end
    fetch_one(2'd1, 32'd0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL reload_stale: got err=%b expected 1", err);
    end
  endtask

  initial begin
    test_reset();
    test_idle_inputs();
    test_back_to_back();
    test_overflow();
    test_out_of_range();
    test_done_with_word();
    test_rst_midload();
    test_reload();
    cyc(); cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending fetches expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
